shift_iter: RTL



---
 rtl/shift_iter.sv | 95 +++++++++
 1 files changed

// File: rtl/shift_iter.sv
// Iterative 16-bit shifter/rotator: applies the amount as 8/4/2/1 steps, one per cycle.
// start/busy/done handshake; out holds the last result until the next operation completes.
module shift_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] in,
  input  logic [3:0]  cnt,
  input  logic [1:0]  op,
  output logic        busy,
  output logic        done,
  output logic [15:0] out
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_nx;
  logic [15:0] data, data_nx;
  logic [3:0]  rem, rem_nx;
  logic [1:0]  opr, opr_nx;
  logic        load_out;
  logic [4:0]  step;
  logic [15:0] stepped;

  // Largest power of two still contained in the remaining amount
  always_comb begin
    if (rem[3])      step = 5'd8;
    else if (rem[2]) step = 5'd4;
    else if (rem[1]) step = 5'd2;
    else             step = 5'd1;
  end

  always_comb begin
    case (opr)
      2'b00:   stepped = (data << step) | (data >> (5'd16 - step));
      2'b01:   stepped = data << step;
      2'b10:   stepped = (data >> step) | (data << (5'd16 - step));
      default: stepped = data >> step;
    endcase
  end

  always_comb begin
    state_nx = state;
    data_nx  = data;
    rem_nx   = rem;
    opr_nx   = opr;
    load_out = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          data_nx = in;
          rem_nx  = cnt;
          opr_nx  = op;
          if (cnt == 4'd0) begin
            state_nx = DONE;
            load_out = 1'b1;
          end else begin
            state_nx = SHIFT;
          end
        end
      end
      SHIFT: begin
        data_nx = stepped;
        rem_nx  = rem - step[3:0];
        // The last step edge is also the DONE entry edge, so out captures the final value here
        if (rem_nx == 4'd0) begin
          state_nx = DONE;
          load_out = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      data  <= 16'h0000;
      rem   <= 4'd0;
      opr   <= 2'b00;
      out   <= 16'h0000;
    end else begin
      state <= state_nx;
      data  <= data_nx;
      rem   <= rem_nx;
      opr   <= opr_nx;
      if (load_out) out <= data_nx;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
